// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU datapath
// and one external master (DMA or coprocessor).
//
// The CPU owns the port by default. A requesting master is granted only after
// the CPU has been frozen through the hold/holdACK handshake. Each tenure is
// capped at MAX_BURST beats, and a FAIR_GAP idle window follows every tenure
// so the CPU always gets the port back for a while.
//
// Handshake semantics (master side): while dma_gnt=1, every cycle with
// dma_req=1 is exactly one beat. A write commits at the rising edge, and a read
// returns combinationally on dma_rdata in the same cycle. dma_last=1 on a beat
// ends the tenure after that beat. Dropping dma_req ends the tenure with no
// beat. The CPU side is frozen whenever hold=1, and it must answer with holdACK.
//
// Optional feature: define ARB_ACK_TIMEOUT_EN to give up on a CPU that does not
// answer hold within ACK_TIMEOUT cycles. The arbiter then pulses ack_err for
// one cycle and retries after the fairness gap. When the macro is not defined,
// HOLD_REQ waits indefinitely and ack_err is tied low.
module dmem_arbiter #(
  parameter int WIDE        = 32,
  parameter int MAX_BURST   = 16,
  parameter int FAIR_GAP    = 4,
  parameter int ACK_TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            cpu_we,
  input  logic [31:0]     cpu_addr,
  input  logic [WIDE-1:0] cpu_wd,
  output logic [WIDE-1:0] cpu_rdata,
  output logic            hold,
  input  logic            holdACK,
  input  logic            dma_req,
  input  logic            dma_we,
  input  logic [31:0]     dma_addr,
  input  logic [WIDE-1:0] dma_wd,
  input  logic            dma_last,
  output logic            dma_gnt,
  output logic [WIDE-1:0] dma_rdata,
  output logic            mem_we,
  output logic [31:0]     mem_addr,
  output logic [WIDE-1:0] mem_d,
  input  logic [WIDE-1:0] mem_q,
  output logic            busy,
  output logic            ack_err
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD_REQ = 2'd1,
    GRANT    = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Elaboration-time range checks. The counters below are 8 bits wide.
  if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
    $error("dmem_arbiter: MAX_BURST must be in 1..255");
  end
  if (FAIR_GAP < 0 || FAIR_GAP > 255) begin : g_bad_fair_gap
    $error("dmem_arbiter: FAIR_GAP must be in 0..255");
  end
  if (ACK_TIMEOUT < 1 || ACK_TIMEOUT > 256) begin : g_bad_ack_timeout
    $error("dmem_arbiter: ACK_TIMEOUT must be in 1..256");
  end

  state_t     state;
  logic [7:0] beat_cnt;
  logic [7:0] gap_cnt;
  logic       last_beat;

`ifdef ARB_ACK_TIMEOUT_EN
  logic [7:0] ack_cnt;
`else
  assign ack_err = 1'b0;
`endif

  // A beat closes the tenure if the master marks it last or it reaches the cap.
  assign last_beat = dma_last || ((beat_cnt + 8'd1) == 8'(MAX_BURST));

  // Arbitration FSM with registered hold/dma_gnt/ack_err outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold     <= 1'b0;
      dma_gnt  <= 1'b0;
      beat_cnt <= 8'd0;
      gap_cnt  <= 8'd0;
`ifdef ARB_ACK_TIMEOUT_EN
      ack_cnt  <= 8'd0;
      ack_err  <= 1'b0;
`endif
    end else begin
`ifdef ARB_ACK_TIMEOUT_EN
      ack_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          // The fairness window must drain fully before a new request is taken.
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end else if (dma_req) begin
            state <= HOLD_REQ;
            hold  <= 1'b1;
`ifdef ARB_ACK_TIMEOUT_EN
            ack_cnt <= 8'd0;
`endif
          end
        end
        HOLD_REQ: begin
          if (!dma_req) begin
            // The master withdrew before the grant, so the tenure has no beats.
            state <= RELEASE;
            hold  <= 1'b0;
          end else if (holdACK) begin
            state    <= GRANT;
            dma_gnt  <= 1'b1;
            beat_cnt <= 8'd0;
          end
`ifdef ARB_ACK_TIMEOUT_EN
          else if (ack_cnt == 8'(ACK_TIMEOUT - 1)) begin
            state   <= RELEASE;
            hold    <= 1'b0;
            ack_err <= 1'b1;
          end else begin
            ack_cnt <= ack_cnt + 8'd1;
          end
`endif
        end
        GRANT: begin
          // A holdACK drop is ignored here. The CPU contract forbids it.
          if (dma_req) begin
            beat_cnt <= beat_cnt + 8'd1;
            if (last_beat) begin
              state   <= RELEASE;
              hold    <= 1'b0;
              dma_gnt <= 1'b0;
            end
          end else begin
            state   <= RELEASE;
            hold    <= 1'b0;
            dma_gnt <= 1'b0;
          end
        end
        RELEASE: begin
          gap_cnt <= 8'(FAIR_GAP);
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          hold    <= 1'b0;
          dma_gnt <= 1'b0;
        end
      endcase
    end
  end

  // Port mux: the CPU store path is cut off whenever the master owns the port.
  assign mem_we    = dma_gnt ? dma_we   : cpu_we;
  assign mem_addr  = dma_gnt ? dma_addr : cpu_addr;
  assign mem_d     = dma_gnt ? dma_wd   : cpu_wd;
  assign cpu_rdata = mem_q;
  assign dma_rdata = mem_q;
  assign busy      = (state != IDLE);

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port between the CPU datapath and one external master (DMA or coprocessor).
- The CPU owns the port by default. A requesting master gets the port only after the CPU is frozen through the hold/holdACK handshake.
- Tenures are bounded by a burst limit, and a minimum CPU gap follows each tenure so the CPU is never starved.
- Sits between the CPU data-side signals and dmem.

Parameters:
- WIDE, 32, data width of the memory port.
- MAX_BURST, 16, maximum DMA beats per tenure (1..255).
- FAIR_GAP, 4, minimum IDLE cycles between tenures (0..255).
- ACK_TIMEOUT, 64, cycles to wait for holdACK (used only with the optional feature).

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- cpu_we  in  1  CPU store enable
- cpu_addr  in  32  CPU byte address
- cpu_wd  in  WIDE  CPU store data
- cpu_rdata  out  WIDE  load data to CPU (= mem_q)
- hold  out  1  freeze request to CPU control
- holdACK  in  1  CPU confirms it is frozen
- dma_req  in  1  master requests/continues transfer; one beat per granted cycle
- dma_we  in  1  master write enable
- dma_addr  in  32  master byte address
- dma_wd  in  WIDE  master write data
- dma_last  in  1  current beat is the final one
- dma_gnt  out  1  master owns the port this cycle
- dma_rdata  out  WIDE  read data to master (= mem_q)
- mem_we  out  1  to dmem we
- mem_addr  out  32  to dmem a
- mem_d  out  WIDE  to dmem d
- mem_q  in  WIDE  from dmem q (combinational read)
- busy  out  1  state != IDLE
- ack_err  out  1  one-cycle holdACK timeout pulse

Behaviour:
- FSM states: IDLE, HOLD_REQ, GRANT, RELEASE. State and hold/dma_gnt are registered Moore outputs.
- Reset (async, immediate) sets:
  - state=IDLE, hold=0, dma_gnt=0, ack_err=0
  - beat_cnt=0, gap_cnt=0
  - port muxed to the CPU
- Port mux:
  - When dma_gnt=1: mem_addr=dma_addr, mem_d=dma_wd, mem_we=dma_we.
  - Otherwise: mem_addr=cpu_addr, mem_d=cpu_wd, mem_we=cpu_we.
  - cpu_we is never passed to dmem while dma_gnt=1.
- IDLE:
  - gap_cnt decrements each cycle until it saturates at 0.
  - At an edge with dma_req=1 and gap_cnt=0, go to HOLD_REQ; hold=1 from the next cycle.
  - A request with gap_cnt>0 is held off until gap_cnt reaches 0.
- HOLD_REQ:
  - hold=1.
  - At an edge with holdACK=1 and dma_req=1, go to GRANT with beat_cnt=0.
  - If dma_req=0 at the edge (abort), go to RELEASE; no beats occur.
- GRANT:
  - hold=1, dma_gnt=1, busy=1.
  - Every cycle with dma_req=1 is one beat: a write is committed at the edge, or a read is returned combinationally on dma_rdata. beat_cnt increments on each beat.
  - Exit to RELEASE at the edge where any of these holds:
    - dma_req=1 and dma_last=1
    - beat_cnt+1 == MAX_BURST on a beat
    - dma_req=0
  - On a burst-limit exit, a master with remaining beats keeps dma_req high and re-arbitrates after the gap.
- RELEASE:
  - One cycle with dma_gnt=0 and hold=0; port returns to the CPU.
  - gap_cnt is loaded with FAIR_GAP; next state is IDLE.
- holdACK falling while in GRANT is ignored; the tenure continues (the CPU contract forbids this).
- beat_cnt width is 8 bits; no wrap is possible within legal MAX_BURST.
- Reset during GRANT drops dma_gnt and hold asynchronously. A write in flight at that moment is not committed if rst is high at the edge.
- cpu_rdata and dma_rdata are always mem_q.

Optional Feature:
- Macro: ARB_ACK_TIMEOUT_EN.
- Defined:
  - An 8-bit counter runs in HOLD_REQ and clears on entry.
  - If ACK_TIMEOUT cycles elapse without holdACK, go to RELEASE and pulse ack_err high for exactly one cycle (the RELEASE cycle).
  - gap_cnt is loaded as normal, so the request retries after the gap.
- Undefined: HOLD_REQ waits indefinitely; ack_err is tied to 0.

Test Plan:
- Reset: assert rst mid-cycle -> hold=0, dma_gnt=0, busy=0, ack_err=0 immediately; cpu_addr=0x10 appears on mem_addr.
- 4-beat write burst:
  - dma_req at edge t -> hold=1 at t+1; holdACK=1 from t+2 -> dma_gnt=1 at t+3.
  - Writes to 0x40/0x44/0x48/0x4C with dma_last on beat 4 -> dmem holds the data; dma_gnt=0 and hold=0 one cycle after beat 4.
  - cpu_we=1 throughout the burst causes no writes.
- Burst limit: 20-beat request with MAX_BURST=16 -> dma_gnt drops after exactly 16 beats; 1 RELEASE cycle plus 4 gap cycles, then hold re-asserts; 4 remaining beats complete.
- Abort: dma_req dropped in HOLD_REQ before holdACK -> RELEASE; zero mem_we pulses from the master; hold low after 1 cycle.
- Timeout (ARB_ACK_TIMEOUT_EN): holdACK held 0 -> ack_err is a single-cycle pulse 64 cycles after hold rises; hold falls; retry after FAIR_GAP.
- Async reset mid-burst at beat 2 -> dma_gnt and hold low without a clock edge; beat 3 data not written; CPU owns the port.
